// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux, with the chosen word held on a valid/ready output.
// Optional per-requester grant counters are enabled by defining MUX4_ARB_STATS_EN.
module mux4_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
`ifdef MUX4_ARB_STATS_EN
    ,
    output logic [63:0]           grant_cnt
`endif
);

    // Handshake: a word transfers when out_valid & out_ready at a rising edge.
    // A requester's word is consumed in the cycle its gnt bit is high.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        ptr;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;
    logic              load;
    logic [DATA_W-1:0] slice [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slice[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts just after the last winner; k=4 wraps back to ptr itself.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign load = ((state == IDLE) || out_ready) && (|req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = HOLD;
        end else if ((state == HOLD) && out_ready) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        gnt       = 4'b0000;
        out_valid = (state == HOLD);
        busy      = (state == HOLD);
        if (load) begin
            gnt[winner] = 1'b1;
        end
    end

    // Reset pointer of 3 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sel      <= 2'd0;
            ptr      <= 2'd3;
        end else if (load) begin
            out_data <= slice[winner];
            sel      <= winner;
            ptr      <= winner;
        end
    end

`ifdef MUX4_ARB_STATS_EN
    for (genvar g = 0; g < 4; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt[16*g +: 16] <= 16'd0;
            end else if (gnt[g] && (grant_cnt[16*g +: 16] != 16'hFFFF)) begin
                grant_cnt[16*g +: 16] <= grant_cnt[16*g +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (DATA_W=8); grant counter checks need MUX4_ARB_STATS_EN.
module tb_mux4_rr_arbiter;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
`ifdef MUX4_ARB_STATS_EN
    logic [63:0]         grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef MUX4_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hA0; exp_d[1] = 8'hB1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD3;

        rst_n = 1'b0; req = 4'b0000; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_gnt",       32'(gnt),       32'd0);
        rst_n = 1'b1;

        // All four requesting: rotation 0,1,2,3,0.
        step();
        req = 4'b1111; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; out_ready = 1'b1;
        settle();
        chk("t1_gnt_first", 32'(gnt), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_out_data",  32'(out_data),  32'(exp_d[i]));
            chk("t1_sel",       32'(sel),       32'(i));
            chk("t1_out_valid", 32'(out_valid), 32'd1);
            chk("t1_gnt_next",  32'(gnt),       32'(4'b0001 << ((i + 1) % 4)));
        end
        step();
        chk("t1_wrap_data", 32'(out_data), 32'hA0);
        req = 4'b0000;
        settle();
        chk("t1_gnt_none", 32'(gnt), 32'd0);
        step();
        chk("t1_drain_valid", 32'(out_valid), 32'd0);
        chk("t1_drain_data",  32'(out_data),  32'hA0);
        chk("t1_drain_sel",   32'(sel),       32'd0);

        // Lone requester 2 (ptr=0).
        req = 4'b0100; in_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        settle();
        chk("t2_gnt", 32'(gnt), 32'b0100);
        step();
        req = 4'b0000;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_sel",       32'(sel),       32'd2);
        chk("t2_out_data",  32'(out_data),  32'h5A);
        step();
        chk("t2_idle", 32'(out_valid), 32'd0);

        // Backpressure: hold 0x77 from requester 1 (ptr becomes 1).
        req = 4'b0010; in_data = {8'h00, 8'h00, 8'h77, 8'h00};
        settle();
        chk("t3_gnt_load", 32'(gnt), 32'b0010);
        step();
        out_ready = 1'b0; req = 4'b1010; in_data = {8'h33, 8'h00, 8'h11, 8'h00};
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_stall_gnt",   32'(gnt),       32'd0);
            chk("t3_stall_data",  32'(out_data),  32'h77);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            step();
        end
        chk("t3_stall_data_end", 32'(out_data), 32'h77);
        out_ready = 1'b1;
        settle();
        chk("t3_release_gnt", 32'(gnt), 32'b1000);
        step();
        chk("t3_data3", 32'(out_data), 32'h33);
        chk("t3_sel3",  32'(sel),      32'd3);
        req = 4'b0010;
        settle();
        chk("t3_gnt1", 32'(gnt), 32'b0010);
        step();
        chk("t3_data1", 32'(out_data), 32'h11);

        // ptr=1, req 0011: search 2,3,0 -> 0, then 1.
        req = 4'b0011; in_data = {8'h00, 8'h00, 8'h41, 8'h40};
        settle();
        chk("t4_gnt0", 32'(gnt), 32'b0001);
        step();
        chk("t4_sel0",  32'(sel),      32'd0);
        chk("t4_data0", 32'(out_data), 32'h40);
        req = 4'b0010;
        settle();
        chk("t4_gnt1", 32'(gnt), 32'b0010);
        step();
        chk("t4_sel1",  32'(sel),      32'd1);
        chk("t4_data1", 32'(out_data), 32'h41);
        req = 4'b0000;
        step();

        // Async reset during HOLD.
        req = 4'b0100; in_data = {8'h00, 8'h99, 8'h00, 8'h00};
        step();
        req = 4'b0000; out_ready = 1'b0;
        chk("t5_hold_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_busy",  32'(busy),      32'd0);
        chk("t5_async_data",  32'(out_data),  32'd0);
        #2 rst_n = 1'b1;
        step();
        req = 4'b1000; in_data = {8'hE7, 8'h00, 8'h00, 8'h00}; out_ready = 1'b1;
        settle();
        chk("t5_gnt3", 32'(gnt), 32'b1000);
        step();
        chk("t5_sel3",  32'(sel),      32'd3);
        chk("t5_data3", 32'(out_data), 32'hE7);
        req = 4'b0000;
        step();

        // Pointer returns to 3 after reset: with ptr=2 before, 1001 would pick 3.
        req = 4'b0100;
        step();
        req = 4'b0000; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        req = 4'b1001; in_data = {8'h3C, 8'h00, 8'h00, 8'h0C}; out_ready = 1'b1;
        settle();
        chk("t5_ptr_reset_gnt", 32'(gnt), 32'b0001);
        step();
        chk("t5_ptr_reset_data", 32'(out_data), 32'h0C);

        // Single requester held: granted on every load, one word per cycle.
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            in_data = {24'h0, 8'(8'h60 + i)};
            settle();
            chk("t7_single_gnt", 32'(gnt), 32'b0001);
            step();
            chk("t7_single_data",  32'(out_data),  32'(8'h60 + i));
            chk("t7_single_valid", 32'(out_valid), 32'd1);
        end
        req = 4'b0000;
        step();

`ifdef MUX4_ARB_STATS_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        req = 4'b0100; out_ready = 1'b1;
        repeat (10) step();
        req = 4'b0000;
        step();
        chk("t6_cnt0", 32'(grant_cnt[15:0]),  32'd0);
        chk("t6_cnt1", 32'(grant_cnt[31:16]), 32'd0);
        chk("t6_cnt2", 32'(grant_cnt[47:32]), 32'd10);
        chk("t6_cnt3", 32'(grant_cnt[63:48]), 32'd0);
        req = 4'b0100;
        repeat (65525) step();
        req = 4'b0000;
        step();
        chk("t6_cnt2_full", 32'(grant_cnt[47:32]), 32'hFFFF);
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        chk("t6_cnt2_sat", 32'(grant_cnt[47:32]), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
